// File: rtl/mfrc522_pkg.sv
// mfrc522_pkg: shared constants and types for the MFRC522 SPI register-interface
// emulation. Holds register addresses, the transaction state enum and the
// address-byte field positions.
package mfrc522_pkg;

  localparam logic [5:0] COMMAND_REG   = 6'h01;
  localparam logic [5:0] FIFO_DATA_REG = 6'h09;
  localparam logic [5:0] VERSION_REG   = 6'h37;

  // Address byte, MSB first: [7]=read, [6:1]=register, [0]=reserved (must be 0)
  localparam int ADDR_RW_BIT   = 7;
  localparam int ADDR_MSB      = 6;
  localparam int ADDR_LSB      = 1;
  localparam int ADDR_RSVD_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_e;

  function automatic logic [5:0] addr_field(input logic [7:0] b);
    return b[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizers for W asynchronous SPI pins plus
// registered rise/fall pulses. A pin edge shows up as a one-cycle pulse three
// clocks later; o_level is aligned with those pulses.
// Ports:
//   i_clk, i_rst     system clock, synchronous active-high reset
//   i_async[W-1:0]   raw pins
//   o_level[W-1:0]   synchronized level, aligned with the pulses
//   o_rise/o_fall    one-cycle edge pulses per pin
module spi_sync_edge #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_s1, r_s2, r_s3, r_rise, r_fall;

  // Everything resets low: a chip select still held low across reset then
  // produces no falling edge, so an interrupted transaction stays ignored
  // until CS is released and asserted again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_level = r_s3;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/mfrc522_spi_responder.sv
// mfrc522_spi_responder: SPI mode-0 target emulating the MFRC522 register
// interface. 64x8 register file, fixed VersionReg, write reporting.
// Ports:
//   i_clk_25mhz, i_rst            system clock, synchronous active-high reset
//   i_spi_sclk/cs_n/mosi          SPI pins (asynchronous)
//   o_spi_miso, o_miso_oe         target data (0 when idle) and tristate enable
//   o_wr_stb/o_wr_addr/o_wr_data  one pulse per completed register write
//   o_busy                        CS asserted
//   o_err_stb                     pulse on address byte with bit0 set
module mfrc522_spi_responder
  import mfrc522_pkg::*;
#(
  parameter logic [7:0] VERSION     = 8'h92,
  parameter logic [7:0] COMMAND_RST = 8'h20
) (
  input  logic       i_clk_25mhz,
  input  logic       i_rst,
  input  logic       i_spi_sclk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_miso_oe,
  output logic       o_wr_stb,
  output logic [5:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  output logic       o_err_stb
);

  logic [2:0] w_level, w_rise, w_fall;

  spi_sync_edge #(.W(3)) u_sync (
    .i_clk   (i_clk_25mhz),
    .i_rst   (i_rst),
    .i_async ({i_spi_mosi, i_spi_cs_n, i_spi_sclk}),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
  assign w_sclk_rise = w_rise[0];
  assign w_sclk_fall = w_fall[0];
  assign w_cs_rise   = w_rise[1];
  assign w_cs_fall   = w_fall[1];
  assign w_mosi      = w_level[2];

  logic w_unused_sync;
  assign w_unused_sync = ^{w_level[1:0], w_rise[2], w_fall[2]};

  state_e     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic       r_null;
  logic [5:0] r_addr;
  logic       r_busy;
  logic       r_wr_stb;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_err_stb;
  logic [7:0] r_mem [64];

  // Byte as it stands once the current rising edge's bit is shifted in
  logic [7:0] w_byte;
  logic [5:0] w_byte_addr;
  logic [7:0] w_rd_data;
  assign w_byte      = {r_rx, w_mosi};
  assign w_byte_addr = addr_field(w_byte);
  assign w_rd_data   = (w_byte_addr == VERSION_REG) ? VERSION : r_mem[w_byte_addr];

  always_ff @(posedge i_clk_25mhz) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_tx      <= 8'h00;
      r_null    <= 1'b0;
      r_addr    <= 6'd0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 6'd0;
      r_wr_data <= 8'h00;
      r_err_stb <= 1'b0;
      for (int i = 0; i < 64; i++) r_mem[i] <= 8'h00;
      r_mem[COMMAND_REG] <= COMMAND_RST;
      r_mem[VERSION_REG] <= VERSION;
    end else begin
      r_wr_stb  <= 1'b0;
      r_err_stb <= 1'b0;
      // CS release wins over a coincident 8th rising edge: no write happens.
      if (w_cs_rise) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_tx      <= 8'h00;
        r_bit_cnt <= 3'd0;
        r_null    <= 1'b0;
      end else if (w_cs_fall) begin
        r_state   <= ADDR;
        r_busy    <= 1'b1;
        r_tx      <= 8'h00;
        r_bit_cnt <= 3'd0;
        r_null    <= 1'b0;
      end else if (r_state != IDLE) begin
        if (w_sclk_rise) begin
          r_rx      <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_state == WDATA) begin
              // Burst writes all land on the latched address
              r_wr_stb  <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_byte;
              if (r_addr != VERSION_REG) r_mem[r_addr] <= w_byte;
              r_tx <= 8'h00;
            end else if (w_byte[ADDR_RSVD_BIT]) begin
              // Malformed address: answer zeros until CS is released
              r_err_stb <= 1'b1;
              r_null    <= 1'b1;
              r_tx      <= 8'h00;
              r_state   <= RDATA;
            end else if (w_byte[ADDR_RW_BIT]) begin
              r_tx    <= r_null ? 8'h00 : w_rd_data;
              r_state <= RDATA;
            end else if (r_state == ADDR) begin
              r_addr  <= w_byte_addr;
              r_tx    <= 8'h00;
              r_state <= WDATA;
            end else begin
              // Write-form byte inside a read burst is just a terminator
              r_tx <= 8'h00;
            end
          end
        end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign o_spi_miso = r_busy & r_tx[7];
  assign o_miso_oe  = r_busy;
  assign o_busy     = r_busy;
  assign o_wr_stb   = r_wr_stb;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_err_stb  = r_err_stb;

endmodule

// File: tb/tb_mfrc522_spi_responder.sv
module tb_mfrc522_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe, wr_stb, busy, err_stb;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;

  int         wr_cnt  = 0;
  int         err_cnt = 0;
  logic [5:0] last_addr = '0;
  logic [7:0] last_data = '0;
  int         busy_drop = 0;

  always #20 clk = ~clk;

  mfrc522_spi_responder #(.VERSION(8'h92), .COMMAND_RST(8'h20)) dut (
    .i_clk_25mhz (clk),
    .i_rst       (rst),
    .i_spi_sclk  (sclk),
    .i_spi_cs_n  (cs_n),
    .i_spi_mosi  (mosi),
    .o_spi_miso  (miso),
    .o_miso_oe   (miso_oe),
    .o_wr_stb    (wr_stb),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy),
    .o_err_stb   (err_stb)
  );

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (err_stb === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    sclk = 1'b0;
    cs_n = 1'b0;
    wait_clks(6);
  endtask

  task automatic cs_high();
    wait_clks(6);
    cs_n = 1'b1;
    wait_clks(10);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before the rising edge
  task automatic shift_bits(input logic [31:0] d, input int n, output logic [31:0] q);
    q = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      wait_clks(6);
      q = {q[30:0], miso};
      if (busy !== 1'b1) busy_drop++;
      sclk = 1'b1;
      wait_clks(6);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [31:0] d, input int n, output logic [31:0] q);
    cs_low();
    shift_bits(d, n, q);
    cs_high();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(10);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clks(5);
    total++; if (miso !== 1'b0)    begin bad++; $display("FAIL reset_miso got %b want 0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got %b want 0", miso_oe); end
    total++; if (wr_stb !== 1'b0)  begin bad++; $display("FAIL reset_wr_stb got %b want 0", wr_stb); end
    total++; if (wr_addr !== 6'h00) begin bad++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (err_stb !== 1'b0) begin bad++; $display("FAIL reset_err_stb got %b want 0", err_stb); end
    rst = 1'b0;
    wait_clks(10);
  endtask

  task automatic test_version();
    logic [31:0] q;
    int w0;
    w0 = wr_cnt; busy_drop = 0;
    xfer(32'h0000EE00, 16, q);
    total++; if (q[15:0] !== 16'h0092) begin bad++; $display("FAIL version_miso got %h want 0092", q[15:0]); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL version_no_wr got %0d want %0d", wr_cnt, w0); end
    total++; if (busy_drop != 0) begin bad++; $display("FAIL version_busy low samples got %0d want 0", busy_drop); end
    total++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin bad++; $display("FAIL version_release busy=%b oe=%b want 0 0", busy, miso_oe); end
  endtask

  task automatic test_write_read();
    logic [31:0] q;
    int w0;
    w0 = wr_cnt;
    xfer(32'h0000020C, 16, q);
    total++; if (wr_cnt != w0 + 1) begin bad++; $display("FAIL wr_count got %0d want %0d", wr_cnt - w0, 1); end
    total++; if (last_addr !== 6'h01) begin bad++; $display("FAIL wr_addr got %h want 01", last_addr); end
    total++; if (last_data !== 8'h0C) begin bad++; $display("FAIL wr_data got %h want 0c", last_data); end
    xfer(32'h00008200, 16, q);
    total++; if (q[15:0] !== 16'h000C) begin bad++; $display("FAIL readback got %h want 000c", q[15:0]); end
  endtask

  task automatic test_burst_read();
    logic [31:0] q;
    do_reset();
    xfer(32'h0082EE00, 24, q);
    total++; if (q[23:0] !== 24'h002092) begin bad++; $display("FAIL burst_read got %h want 002092", q[23:0]); end
  endtask

  task automatic test_burst_write();
    logic [31:0] q;
    int w0;
    w0 = wr_cnt;
    xfer(32'h0012AA55, 24, q);
    total++; if (wr_cnt != w0 + 2) begin bad++; $display("FAIL burst_wr_count got %0d want 2", wr_cnt - w0); end
    total++; if (last_addr !== 6'h09 || last_data !== 8'h55) begin bad++; $display("FAIL burst_wr_last got %h/%h want 09/55", last_addr, last_data); end
    xfer(32'h00009200, 16, q);
    total++; if (q[15:0] !== 16'h0055) begin bad++; $display("FAIL fifo_read got %h want 0055", q[15:0]); end
  endtask

  task automatic test_protect();
    logic [31:0] q;
    int w0;
    w0 = wr_cnt;
    xfer(32'h00006E00, 16, q);
    total++; if (wr_cnt != w0 + 1) begin bad++; $display("FAIL prot_wr_count got %0d want 1", wr_cnt - w0); end
    total++; if (last_addr !== 6'h37 || last_data !== 8'h00) begin bad++; $display("FAIL prot_wr_last got %h/%h want 37/00", last_addr, last_data); end
    xfer(32'h0000EE00, 16, q);
    total++; if (q[15:0] !== 16'h0092) begin bad++; $display("FAIL prot_version got %h want 0092", q[15:0]); end
  endtask

  task automatic test_abort();
    logic [31:0] q;
    int w0;
    w0 = wr_cnt;
    xfer(32'h0000005F, 13, q);  // 0x02 then 5 data bits
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL abort_no_wr got %0d want 0", wr_cnt - w0); end
    xfer(32'h00008200, 16, q);
    total++; if (q[15:0] !== 16'h0020) begin bad++; $display("FAIL abort_reg1 got %h want 0020", q[15:0]); end
  endtask

  task automatic test_malformed();
    logic [31:0] q;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    xfer(32'h0000EF00, 16, q);
    total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL err_count got %0d want 1", err_cnt - e0); end
    total++; if (q[15:0] !== 16'h0000) begin bad++; $display("FAIL err_miso got %h want 0000", q[15:0]); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL err_no_wr got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    int w0;
    xfer(32'h0000020C, 16, q);  // make reg[1] differ from its reset value
    w0 = wr_cnt;
    cs_low();
    shift_bits(32'h02, 8, q);
    shift_bits(32'h3, 4, q);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(1);
    total++; if (miso !== 1'b0 || miso_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl miso=%b oe=%b busy=%b want 0 0 0", miso, miso_oe, busy); end
    total++; if (wr_addr !== 6'h00 || wr_data !== 8'h00) begin bad++; $display("FAIL mid_rst_wr got %h/%h want 00/00", wr_addr, wr_data); end
    total++; if (wr_stb !== 1'b0 || err_stb !== 1'b0) begin bad++; $display("FAIL mid_rst_stb wr=%b err=%b want 0 0", wr_stb, err_stb); end
    shift_bits(32'h3, 4, q);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ignored busy got %b want 0", busy); end
    cs_high();
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL mid_rst_no_wr got %0d want 0", wr_cnt - w0); end
    xfer(32'h00008200, 16, q);
    total++; if (q[15:0] !== 16'h0020) begin bad++; $display("FAIL mid_rst_reg1 got %h want 0020", q[15:0]); end
  endtask

  initial begin
    test_reset();
    test_version();
    test_write_read();
    test_burst_read();
    test_burst_write();
    test_protect();
    test_abort();
    test_malformed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
